perceptron_train_sequencer: RTL and testbench

- Sequences training and evaluation of a PerceptronIntroduction instance, replacing bench-driven stimulus.
- Holds up to MAX_SAMPLES labelled samples in a local sample memory.
- Per epoch: one training pass over all samples, then one evaluation pass that counts correct predictions.
- Stops early when an evaluation pass is 100% correct, otherwise at the epoch limit. Sits between a host/config interface and the perceptron datapath.

---
 rtl/perceptron_train_sequencer_pkg.sv | 31 +++
 rtl/perceptron_sample_mem.sv | 22 ++
 rtl/perceptron_train_sequencer.sv | 145 ++++++++++++++
 tb/tb_perceptron_train_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_train_sequencer_pkg.sv
// Shared types for the perceptron training sequencer: Q8.8 fixed point,
// sequencer states and the stored sample format.
package perceptron_train_sequencer_pkg;
  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp SFP_ONE = sfp'(1 <<< SFP_FRAC);

  function automatic sfp int_to_sfp(input int i);
    return sfp'(i <<< SFP_FRAC);
  endfunction

  // Sample width is fixed here; the top's INPUT_UNITS must match it.
  localparam int SEQ_INPUT_UNITS       = 2;
  localparam int DEFAULT_SAMPLE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_EVAL,
    ST_CHECK,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    sfp [SEQ_INPUT_UNITS-1:0] values;
    sfp                       expected;
  } sample_t;
endpackage

// File: rtl/perceptron_sample_mem.sv
// Labelled sample store: one synchronous write port, combinational read.
module perceptron_sample_mem
  import perceptron_train_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  sample_t           wdata,
  input  logic [ADDR_W-1:0] raddr,
  output sample_t           rdata
);
  sample_t mem [DEPTH];

  // Contents deliberately survive reset so a run can follow a reset without reload.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/perceptron_train_sequencer.sv
// Drives a perceptron through train/evaluate epochs over a local sample store,
// stopping on a fully correct evaluation pass or at the epoch limit.
module perceptron_train_sequencer
  import perceptron_train_sequencer_pkg::*;
#(
  parameter int  INPUT_UNITS   = SEQ_INPUT_UNITS,
  parameter int  MAX_SAMPLES   = 16,
  parameter int  SAMPLE_CYCLES = DEFAULT_SAMPLE_CYCLES,
  parameter int  EPOCH_W       = 8,
  localparam int CNT_W         = $clog2(MAX_SAMPLES+1),
  localparam int ADDR_W        = $clog2(MAX_SAMPLES)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       cfg_num_samples,
  input  logic [EPOCH_W-1:0]     cfg_max_epochs,
  input  sfp                     cfg_learning_rate,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  sfp [INPUT_UNITS-1:0]   wr_values,
  input  sfp                     wr_expected,
  output sfp [INPUT_UNITS-1:0]   pc_values,
  output sfp                     pc_expected,
  output logic                   pc_training,
  output sfp                     pc_learning_rate,
  input  sfp                     pc_prediction,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic [EPOCH_W-1:0]     epoch_count,
  output logic [CNT_W-1:0]       last_correct
);
  localparam int CYC_W = $clog2(SAMPLE_CYCLES);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   n_q, correct_q, n_eff;
  logic [EPOCH_W-1:0] max_ep_q;
  sfp                 lr_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [CYC_W-1:0]   cyc_q;
  sample_t            wr_sample, rd_sample;
  logic               slot_end, last_slot, presenting, all_correct, last_epoch;
  logic               wr_ok, mem_we;

  assign n_eff       = (cfg_num_samples > CNT_W'(MAX_SAMPLES)) ? CNT_W'(MAX_SAMPLES) : cfg_num_samples;
  assign slot_end    = (cyc_q == CYC_W'(SAMPLE_CYCLES-1));
  assign last_slot   = ((CNT_W'(idx_q) + CNT_W'(1)) == n_q);
  assign presenting  = (state_q == ST_TRAIN) || (state_q == ST_EVAL);
  assign all_correct = (correct_q == n_q);
  assign last_epoch  = ((epoch_count + EPOCH_W'(1)) == max_ep_q);
  assign wr_ok       = (32'(wr_addr) < 32'(MAX_SAMPLES));
  assign mem_we      = wr_en && wr_ok && (state_q == ST_IDLE);
  assign wr_sample   = {wr_values, wr_expected};

  perceptron_sample_mem #(
    .DEPTH  (MAX_SAMPLES),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (wr_sample),
    .raddr (idx_q),
    .rdata (rd_sample)
  );

  assign pc_values        = presenting ? rd_sample.values : '0;
  assign pc_expected      = presenting ? rd_sample.expected : '0;
  assign pc_training      = (state_q == ST_TRAIN);
  assign busy             = presenting || (state_q == ST_CHECK);
  assign pc_learning_rate = busy ? lr_q : '0;
  assign done             = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start) state_d = (n_eff == '0 || cfg_max_epochs == '0) ? ST_DONE : ST_TRAIN;
      ST_TRAIN:
        if (slot_end && last_slot) state_d = ST_EVAL;
      ST_EVAL:
        if (slot_end && last_slot) state_d = ST_CHECK;
      ST_CHECK:
        state_d = (all_correct || last_epoch) ? ST_DONE : ST_TRAIN;
      ST_DONE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      max_ep_q     <= '0;
      lr_q         <= '0;
      idx_q        <= '0;
      cyc_q        <= '0;
      correct_q    <= '0;
      converged    <= 1'b0;
      epoch_count  <= '0;
      last_correct <= '0;
    end else begin
      state_q <= state_d;
      // Abort suppresses every bookkeeping update in its cycle.
      if (!abort) begin
        case (state_q)
          ST_IDLE:
            if (start) begin
              n_q          <= n_eff;
              max_ep_q     <= cfg_max_epochs;
              lr_q         <= cfg_learning_rate;
              idx_q        <= '0;
              cyc_q        <= '0;
              correct_q    <= '0;
              converged    <= 1'b0;
              epoch_count  <= '0;
              last_correct <= '0;
            end
          ST_TRAIN, ST_EVAL: begin
            if (slot_end) begin
              cyc_q <= '0;
              idx_q <= last_slot ? '0 : idx_q + 1'b1;
              if (state_q == ST_TRAIN && last_slot) correct_q <= '0;
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
            if (state_q == ST_EVAL && slot_end && pc_prediction == rd_sample.expected)
              correct_q <= correct_q + 1'b1;
          end
          ST_CHECK: begin
            last_correct <= correct_q;
            epoch_count  <= epoch_count + 1'b1;
            if (all_correct) converged <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Bench for perceptron_train_sequencer with a behavioural perceptron and an epoch-level reference.
module tb_perceptron_train_sequencer;
  import perceptron_train_sequencer_pkg::*;
  localparam int IU = 2, MS = 16, SC = 2, EW = 8;
  localparam int CW = $clog2(MS+1), AW = $clog2(MS);
  localparam int ONE = 256;

  logic clk = 0, rst = 0, start = 0, abort = 0, wr_en = 0;
  logic [CW-1:0] cfg_num_samples = '0;
  logic [EW-1:0] cfg_max_epochs = '0;
  sfp cfg_learning_rate = '0;
  logic [AW-1:0] wr_addr = '0;
  sfp [IU-1:0] wr_values = '0;
  sfp wr_expected = '0;
  sfp [IU-1:0] pc_values;
  sfp pc_expected, pc_learning_rate, pc_prediction;
  logic pc_training, busy, done, converged;
  logic [EW-1:0] epoch_count;
  logic [CW-1:0] last_correct;

  int n_chk = 0, n_fail = 0;
  int sv0[MS], sv1[MS], slab[MS];
  bit stub = 0, clr_w = 0;
  int w0 = 0, w1 = 0, bias = 0, train_cycles = 0;

  perceptron_train_sequencer #(.INPUT_UNITS(IU), .MAX_SAMPLES(MS), .SAMPLE_CYCLES(SC), .EPOCH_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_samples(cfg_num_samples), .cfg_max_epochs(cfg_max_epochs), .cfg_learning_rate(cfg_learning_rate),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_values(wr_values), .wr_expected(wr_expected),
    .pc_values(pc_values), .pc_expected(pc_expected), .pc_training(pc_training),
    .pc_learning_rate(pc_learning_rate), .pc_prediction(pc_prediction),
    .busy(busy), .done(done), .converged(converged), .epoch_count(epoch_count), .last_correct(last_correct));

  always #5 clk = ~clk;

  // Step-activation perceptron in Q8.8: fires ONE when w.x + b > 0.
  function automatic int pred_fn(input int a, input int b, input int c, input int x0, input int x1, input bit stb);
    int s;
    s = ((a * x0) >>> 8) + ((b * x1) >>> 8) + c;
    return (stb || s <= 0) ? 0 : ONE;
  endfunction

  function automatic int dlt(input int lr, input int e, input int p);
    return (lr * (e - p)) >>> 8;
  endfunction

  always_comb pc_prediction = sfp'(pred_fn(w0, w1, bias, int'(pc_values[0]), int'(pc_values[1]), stub));

  always @(posedge clk) begin
    if (clr_w) begin
      w0 <= 0; w1 <= 0; bias <= 0;
    end else if (pc_training && !stub) begin
      w0   <= w0 + ((dlt(int'(pc_learning_rate), int'(pc_expected), int'(pc_prediction)) * int'(pc_values[0])) >>> 8);
      w1   <= w1 + ((dlt(int'(pc_learning_rate), int'(pc_expected), int'(pc_prediction)) * int'(pc_values[1])) >>> 8);
      bias <= bias + dlt(int'(pc_learning_rate), int'(pc_expected), int'(pc_prediction));
    end
  end

  always @(negedge clk) if (pc_training) train_cycles <= train_cycles + 1;

  // Epoch-level reference: every training sample is applied SC times, then one scoring pass.
  function automatic void ref_run(input int n, input int maxe, input int lr, input bit stb,
                                  output int e, output bit cv, output int lc);
    int a, b, c, p, d, corr;
    a = 0; b = 0; c = 0; e = 0; cv = 0; lc = 0;
    if (n == 0 || maxe == 0) return;
    while (1) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < SC; k++)
          if (!stb) begin
            p = pred_fn(a, b, c, sv0[i], sv1[i], stb);
            d = dlt(lr, slab[i], p);
            a += (d * sv0[i]) >>> 8;
            b += (d * sv1[i]) >>> 8;
            c += d;
          end
      corr = 0;
      for (int i = 0; i < n; i++) if (pred_fn(a, b, c, sv0[i], sv1[i], stb) == slab[i]) corr++;
      e++; lc = corr;
      if (corr == n) begin cv = 1; break; end
      if (e == maxe) break;
    end
  endfunction

  task automatic load(input int i);
    @(negedge clk);
    wr_en = 1; wr_addr = AW'(i);
    wr_values[0] = sfp'(sv0[i]); wr_values[1] = sfp'(sv1[i]); wr_expected = sfp'(slab[i]);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic load_and();
    sv0[0] = 0;   sv1[0] = 0;   slab[0] = 0;
    sv0[1] = 0;   sv1[1] = ONE; slab[1] = 0;
    sv0[2] = ONE; sv1[2] = 0;   slab[2] = 0;
    sv0[3] = ONE; sv1[3] = ONE; slab[3] = ONE;
    for (int i = 0; i < 4; i++) load(i);
  endtask

  task automatic start_run(input int cfg_n, input int maxe, input int lr);
    @(negedge clk);
    cfg_num_samples = CW'(cfg_n); cfg_max_epochs = EW'(maxe); cfg_learning_rate = sfp'(lr);
    start = 1; clr_w = 1;
    @(negedge clk);
    start = 0; clr_w = 0;
  endtask

  task automatic wait_done(input int lat0, input int limit, output int lat);
    lat = lat0;
    while (!done && lat < limit) begin @(negedge clk); lat++; end
  endtask

  task automatic run_check(input string nm, input int cfg_n, input int maxe, input int lr);
    int e, lc, lat, n, t0, exp_lat;
    bit cv;
    n = (cfg_n > MS) ? MS : cfg_n;
    ref_run(n, maxe, lr, stub, e, cv, lc);
    exp_lat = e * (2 * n * SC + 1);
    t0 = train_cycles;
    start_run(cfg_n, maxe, lr);
    if (e > 0) begin
      n_chk++; if (busy !== 1'b1 || pc_learning_rate !== sfp'(lr)) begin n_fail++;
        $display("FAIL %s busy/lr: got %0b/%0d want 1/%0d", nm, busy, pc_learning_rate, lr); end
    end
    wait_done(0, 4000, lat);
    n_chk++; if (lat !== exp_lat || done !== 1'b1) begin n_fail++;
      $display("FAIL %s latency: got %0d (done=%0b) want %0d", nm, lat, done, exp_lat); end
    n_chk++; if (converged !== cv) begin n_fail++;
      $display("FAIL %s converged: got %0b want %0b", nm, converged, cv); end
    n_chk++; if (epoch_count !== EW'(e)) begin n_fail++;
      $display("FAIL %s epoch_count: got %0d want %0d", nm, epoch_count, e); end
    n_chk++; if (last_correct !== CW'(lc)) begin n_fail++;
      $display("FAIL %s last_correct: got %0d want %0d", nm, last_correct, lc); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL %s done pulse: done=%0b busy=%0b after pulse, want 0/0", nm, done, busy); end
    if (e == 0) begin
      n_chk++; if (train_cycles !== t0) begin n_fail++;
        $display("FAIL %s no training: got %0d training cycles want 0", nm, train_cycles - t0); end
    end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    n_chk++; if ({busy, done, converged, pc_training} !== 4'b0) begin n_fail++;
      $display("FAIL reset flags: got %b want 0000", {busy, done, converged, pc_training}); end
    n_chk++; if (epoch_count !== '0 || last_correct !== '0) begin n_fail++;
      $display("FAIL reset counters: got %0d/%0d want 0/0", epoch_count, last_correct); end
    n_chk++; if (pc_values !== '0 || pc_expected !== '0 || pc_learning_rate !== '0) begin n_fail++;
      $display("FAIL reset pc bus: got %h/%h/%h want 0", pc_values, pc_expected, pc_learning_rate); end
    rst = 1;
  endtask

  task automatic test_and();
    stub = 0;
    load_and();
    run_check("and_gate", 4, 10, ONE);
    n_chk++; if (converged !== 1'b1 || last_correct !== CW'(4) || epoch_count > EW'(10)) begin n_fail++;
      $display("FAIL and_converge: got conv=%0b last=%0d ep=%0d want 1/4/<=10", converged, last_correct, epoch_count); end
  endtask

  task automatic test_stub();
    stub = 1;
    run_check("stub_limit", 4, 3, ONE);
    n_chk++; if (converged !== 1'b0 || epoch_count !== EW'(3) || last_correct !== CW'(3)) begin n_fail++;
      $display("FAIL stub_const: got conv=%0b ep=%0d last=%0d want 0/3/3", converged, epoch_count, last_correct); end
    stub = 0;
  endtask

  task automatic test_empty();
    run_check("zero_samples", 0, 5, ONE);
    run_check("zero_epochs", 4, 0, ONE);
  endtask

  task automatic test_abort();
    int k, seen;
    stub = 0;
    start_run(4, 10, ONE);
    k = 0; while (epoch_count != 1 && k < 500) begin @(negedge clk); k++; end
    while (!pc_training && k < 500) begin @(negedge clk); k++; end
    while (pc_training && k < 500) begin @(negedge clk); k++; end
    n_chk++; if (k >= 500 || busy !== 1'b1) begin n_fail++;
      $display("FAIL abort_reach_eval: got k=%0d busy=%0b want eval of epoch 2", k, busy); end
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || pc_training !== 1'b0 || pc_learning_rate !== '0) begin n_fail++;
      $display("FAIL abort_idle: got busy=%0b done=%0b trn=%0b lr=%0d want 0", busy, done, pc_training, pc_learning_rate); end
    seen = 0;
    repeat (6) begin @(negedge clk); if (done || busy) seen++; end
    n_chk++; if (seen !== 0) begin n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
    run_check("abort_rerun", 4, 10, ONE);
  endtask

  task automatic test_wr_busy();
    int lat, e, lc, prev, mono;
    bit cv;
    stub = 0;
    ref_run(4, 10, ONE, 0, e, cv, lc);
    start_run(4, 10, ONE);
    repeat (2) @(negedge clk);
    wr_en = 1; wr_addr = '0; wr_values[0] = sfp'(ONE); wr_values[1] = sfp'(ONE); wr_expected = sfp'(ONE);
    start = 1;
    @(negedge clk);
    wr_en = 0; start = 0;
    lat = 3; mono = 1; prev = 0;
    while (!done && lat < 4000) begin
      if (int'(epoch_count) < prev) mono = 0;
      prev = int'(epoch_count);
      @(negedge clk); lat++;
    end
    n_chk++; if (lat !== e * (2 * 4 * SC + 1) || mono !== 1) begin n_fail++;
      $display("FAIL busy_ignore: got lat=%0d mono=%0d want lat=%0d mono=1", lat, mono, e * (2 * 4 * SC + 1)); end
    n_chk++; if (converged !== cv || epoch_count !== EW'(e)) begin n_fail++;
      $display("FAIL busy_ignore_result: got conv=%0b ep=%0d want %0b/%0d", converged, epoch_count, cv, e); end
    @(negedge clk);
    run_check("mem_unchanged", 4, 10, ONE);
  endtask

  task automatic test_reset_mid();
    stub = 0;
    start_run(4, 10, ONE);
    repeat (40) @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_chk++; if ({busy, done, converged, pc_training} !== 4'b0 || epoch_count !== '0 || last_correct !== '0) begin n_fail++;
      $display("FAIL midrun_reset: got flags=%b ep=%0d last=%0d want 0", {busy, done, converged, pc_training}, epoch_count, last_correct); end
    n_chk++; if (pc_values !== '0 || pc_expected !== '0 || pc_learning_rate !== '0) begin n_fail++;
      $display("FAIL midrun_reset_bus: got %h/%h/%h want 0", pc_values, pc_expected, pc_learning_rate); end
    rst = 1;
    run_check("after_reset", 4, 10, ONE);
  endtask

  task automatic test_random();
    int vals[3] = '{-ONE, 0, ONE};
    int n, fn, maxe, lr, cfg_n;
    for (int it = 0; it < 6; it++) begin
      n  = (it == 5) ? MS : int'($urandom_range(1, MS));
      fn = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        sv0[i] = vals[$urandom_range(0, 2)];
        sv1[i] = vals[$urandom_range(0, 2)];
        case (fn)
          0:       slab[i] = (sv0[i] > 0 && sv1[i] > 0) ? ONE : 0;
          1:       slab[i] = (sv0[i] > 0 || sv1[i] > 0) ? ONE : 0;
          default: slab[i] = $urandom_range(0, 1) ? ONE : 0;
        endcase
        load(i);
      end
      stub  = ($urandom_range(0, 3) == 0);
      maxe  = int'($urandom_range(1, 8));
      lr    = $urandom_range(0, 1) ? ONE : ONE / 2;
      cfg_n = (it == 5) ? 20 : n;
      run_check($sformatf("random%0d", it), cfg_n, maxe, lr);
    end
    stub = 0;
  endtask

  initial begin
    test_reset();
    test_and();
    test_stub();
    test_empty();
    load_and();
    test_abort();
    test_wr_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
